frame_fifo_reader: RTL and testbench



---
 rtl/frame_fifo_reader.sv | 216 +++++++++++++++++++++
 tb/tb_frame_fifo_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fifo_reader.sv
// Read-side consumer of the switch's frame FIFO: prefetches bytes into a 2-entry
// skid buffer and re-frames the byte+EOD stream into a valid/ready byte stream.
module frame_fifo_reader #(
    parameter int MAX_LEN       = 1518,
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 2048,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       fifo_do,
    input  logic             fifo_eod,
    input  logic             fifo_empty,
    input  logic             fifo_aempty,
    output logic             fifo_re,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    output logic             m_err,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic [1:0]       fsm_state
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        STREAM     = 2'd1,
        DRAIN      = 2'd2,
        GAP        = 2'd3
    } state_t;

    // Where a frame end (normal or after draining) leads.
    localparam state_t END_ST = (IFG_CYCLES == 0) ? WAIT_START : GAP;

    state_t state;
    state_t state_next;

    // Skid buffer: each entry is {eod, data}.
    logic [8:0]       buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic             in_flight;

    logic [LEN_W-1:0] len_cnt;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;

    logic             buf_nonempty;
    logic             head_eod;
    logic             at_max;
    logic             pop;
    logic             frame_end;
    logic             trunc;
    logic             drain_end;
    logic             timer_hit;
    logic             gap_done;
    logic [2:0]       occ_after;

    assign buf_nonempty = (occ != 2'd0);
    assign head_eod     = buf_mem[rd_ptr][8];
    assign at_max       = (len_cnt == LEN_W'(MAX_LEN - 1));
    assign timer_hit    = (timer == TMR_W'(START_TIMEOUT - 1));
    assign gap_done     = (gap_cnt == GAP_W'(IFG_CYCLES - 1));

    assign frame_end = (state == STREAM) && pop && head_eod;
    assign trunc     = (state == STREAM) && pop && at_max && !head_eod;
    assign drain_end = (state == DRAIN) && pop && head_eod;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_START;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_START: begin
                if (!fifo_aempty || (timer_hit && (!fifo_empty || buf_nonempty))) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (frame_end) begin
                    state_next = END_ST;
                end else if (trunc) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_end) begin
                    state_next = END_ST;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_next = WAIT_START;
                end
            end
            default: state_next = WAIT_START;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Handshake: a byte transfers on a rising clk edge where m_valid and
    // m_ready are both high; m_valid never waits on m_ready, and while
    // m_valid=1 and m_ready=0 the head entry (data/last/err) is held.
    // ------------------------------------------------------------------
    always_comb begin
        m_valid = 1'b0;
        pop     = 1'b0;
        fifo_re = 1'b0;
        unique case (state)
            STREAM: begin
                m_valid = buf_nonempty;
                pop     = buf_nonempty && m_ready;
            end
            DRAIN: begin
                pop = buf_nonempty;
            end
            default: begin
                m_valid = 1'b0;
                pop     = 1'b0;
            end
        endcase
        // A slot freed by this cycle's pop counts as free, so one read per
        // clock keeps the buffer at one entry and sustains 1 byte/clk.
        if (((state == STREAM) || (state == DRAIN)) && !fifo_empty && (occ_after < 3'd2)) begin
            fifo_re = 1'b1;
        end
    end

    assign occ_after = {1'b0, occ} - {2'b00, pop} + {2'b00, in_flight};

    assign m_data    = buf_mem[rd_ptr][7:0];
    assign m_last    = m_valid && (head_eod || at_max);
    assign m_err     = m_valid && at_max && !head_eod;
    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Skid buffer and read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0] <= 9'd0;
            buf_mem[1] <= 9'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            in_flight  <= 1'b0;
        end else begin
            if (in_flight) begin
                buf_mem[wr_ptr] <= {fifo_eod, fifo_do};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ       <= occ + {1'b0, in_flight} - {1'b0, pop};
            in_flight <= fifo_re;
        end
    end

    // ------------------------------------------------------------------
    // Length, timers and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt   <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            trunc_cnt <= '0;
        end else begin
            if ((state == STREAM) && pop) begin
                len_cnt <= (frame_end || trunc) ? '0 : len_cnt + LEN_W'(1);
            end

            // The start timer only runs in WAIT_START and parks at its limit.
            if (state != WAIT_START) begin
                timer <= '0;
            end else if (!timer_hit) begin
                timer <= timer + TMR_W'(1);
            end

            if (state != GAP) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end

            if (frame_end) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (trunc) begin
                trunc_cnt <= trunc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_fifo_reader.sv
// Randomized bench for frame_fifo_reader: a queue-based FIFO model feeds the DUT and
// a frame-level reference model predicts every output byte and the statistics.
module tb_frame_fifo_reader;

    localparam int MAX_LEN       = 1518;
    localparam int IFG           = 12;
    localparam int START_TIMEOUT = 2048;
    localparam int CNT_W         = 16;
    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       fifo_do;
    logic             fifo_eod;
    logic             fifo_empty;
    logic             fifo_aempty;
    logic             fifo_re;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_err;
    logic             m_ready;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] trunc_cnt;
    logic [1:0]       fsm_state;

    frame_fifo_reader #(
        .MAX_LEN      (MAX_LEN),
        .IFG_CYCLES   (IFG),
        .START_TIMEOUT(START_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_do    (fifo_do),
        .fifo_eod   (fifo_eod),
        .fifo_empty (fifo_empty),
        .fifo_aempty(fifo_aempty),
        .fifo_re    (fifo_re),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_err      (m_err),
        .m_ready    (m_ready),
        .frame_cnt  (frame_cnt),
        .trunc_cnt  (trunc_cnt),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- model state / scoreboard ----------------
    logic [8:0] fifo_q[$];   // {eod, data} bytes still inside the FIFO
    logic [9:0] exp_q[$];    // {err, last, data} bytes expected on the output
    int   total = 0;
    int   bad = 0;
    int   exp_frames = 0;
    int   exp_trunc = 0;
    int   hs_cnt = 0;
    int   ready_mode = 0;    // 0: always ready, 1: toggle, 2: random
    logic ready_tog = 1'b0;
    logic stall = 1'b0;
    logic aempty_hold = 1'b0;
    logic rd_acc = 1'b0;
    logic gap_track = 1'b0;
    int   gap_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_frame(input int len);
        logic [7:0] d;
        for (int i = 1; i <= len; i++) begin
            d = 8'($urandom);
            fifo_q.push_back({(i == len), d});
            if (i <= MAX_LEN) begin
                exp_q.push_back({((i == MAX_LEN) && (len > MAX_LEN)), ((i == len) || (i == MAX_LEN)), d});
            end
        end
        if (len > MAX_LEN) exp_trunc++;
        else exp_frames++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0) && (c < budget)) begin
            step(1);
            c++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        step(IFG + 4);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames % (1 << CNT_W)));
        check({tag, "_trunc_cnt"}, 32'(trunc_cnt), 32'(exp_trunc % (1 << CNT_W)));
    endtask

    task automatic wait_handshakes(input string tag, input int n);
        int target;
        int c;
        target = hs_cnt + n;
        c = 0;
        while ((hs_cnt < target) && (c < 2000)) begin
            step(1);
            c++;
        end
        check({tag, "_progress"}, 32'(hs_cnt >= target), 32'd1);
    endtask

    // FIFO model, ready policy and output monitor, all on the falling edge.
    always @(negedge clk) begin
        if (rd_acc && (fifo_q.size() > 0)) begin
            {fifo_eod, fifo_do} = fifo_q.pop_front();
        end
        fifo_empty  = stall || (fifo_q.size() == 0);
        fifo_aempty = aempty_hold || (fifo_q.size() < 4);
        case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
                ready_tog = ~ready_tog;
                m_ready   = ready_tog;
            end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (rst_n) begin
            check("re_while_empty", 32'(fifo_re & fifo_empty), 32'd0);
            rd_acc = fifo_re & ~fifo_empty;
            if (m_valid) begin
                if (gap_track) begin
                    check("ifg_len", 32'(gap_cnt >= IFG), 32'd1);
                    gap_track = 1'b0;
                end
                if (m_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(m_valid), 32'd0);
                    end else begin
                        check("byte", {22'd0, m_err, m_last, m_data}, {22'd0, exp_q.pop_front()});
                    end
                    if (m_last) begin
                        gap_track = 1'b1;
                        gap_cnt   = 0;
                    end
                end
            end else if (gap_track) begin
                gap_cnt++;
            end
        end else begin
            rd_acc = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int run;
        int zeros;

        fifo_do     = 8'd0;
        fifo_eod    = 1'b0;
        fifo_empty  = 1'b1;
        fifo_aempty = 1'b1;
        m_ready     = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_outputs", {19'd0, fifo_re, m_valid, m_last, m_err, m_data}, 32'd0);
        check("rst_counters", {frame_cnt, trunc_cnt}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});

        // Start timeout: almost-empty held, frame waits out the timer.
        aempty_hold = 1'b1;
        load_frame(10);
        #6 rst_n = 1'b1;
        cyc = 0;
        while (!m_valid && (cyc < START_TIMEOUT + 100)) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("timeout_start", 32'((cyc >= START_TIMEOUT) && (cyc <= START_TIMEOUT + 4)), 32'd1);
        wait_drain("timeout", 200);
        check_counters("timeout");
        aempty_hold = 1'b0;

        // 64-byte frame at full rate: contiguous valid, then an idle gap.
        ready_mode = 0;
        step(1);
        load_frame(64);
        cyc = 0;
        while (!m_valid && (cyc < 50)) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        run = 0;
        while (m_valid && (run < 200)) begin
            run++;
            @(negedge clk);
            #2;
        end
        check("full_rate_run", 32'(run), 32'd64);
        zeros = 0;
        repeat (IFG) begin
            if (!m_valid) zeros++;
            @(negedge clk);
            #2;
        end
        check("full_rate_gap", 32'(zeros), 32'(IFG));
        wait_drain("full_rate", 100);
        check_counters("full_rate");

        // Two back-to-back frames with alternating ready.
        ready_mode = 1;
        load_frame(60);
        load_frame(60);
        wait_drain("b2b", 1000);
        check_counters("b2b");

        // Oversized frame is truncated, the following frame is clean.
        ready_mode = 2;
        load_frame(1600);
        load_frame(20);
        wait_drain("trunc", 10000);
        check_counters("trunc");

        // FIFO stall mid-frame.
        ready_mode = 0;
        load_frame(200);
        wait_handshakes("stall", 50);
        stall = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (i >= 5) begin
                check("stall_valid", 32'(m_valid), 32'd0);
                check("stall_state", {30'd0, fsm_state}, {30'd0, ST_STREAM});
            end
        end
        stall = 1'b0;
        wait_drain("stall", 1000);
        check_counters("stall");

        // Random frames including the exact-limit and one-over-limit cases.
        ready_mode = 2;
        for (int k = 0; k < 6; k++) load_frame($urandom_range(1, 100));
        load_frame(MAX_LEN);
        load_frame(MAX_LEN + 1);
        load_frame($urandom_range(1, 30));
        wait_drain("random", 16000);
        check_counters("random");

        // Asynchronous reset mid-frame.
        ready_mode = 0;
        load_frame(100);
        wait_handshakes("reset", 30);
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        rd_acc     = 1'b0;
        gap_track  = 1'b0;
        exp_frames = 0;
        exp_trunc  = 0;
        #1;
        check("arst_outputs", {19'd0, fifo_re, m_valid, m_last, m_err, m_data}, 32'd0);
        check("arst_counters", {frame_cnt, trunc_cnt}, 32'd0);
        check("arst_state", {30'd0, fsm_state}, {30'd0, ST_WAIT});
        @(posedge clk);
        #4 rst_n = 1'b1;
        step(2);
        load_frame(40);
        wait_drain("post_reset", 400);
        check_counters("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
